// File: rtl/bcd_to_n_digit_mux_if.sv
// bcd_to_n_digit_mux_if
//   Bundles the application-side inputs and the board-side pin outputs of
//   the multiplexed 7-segment driver.
//   master : application/board side (drives the codes, observes the pins)
//   slave  : the driver itself
//   bcd_in     packed BCD codes, [3:0] = digit 0 (rightmost)
//   dp_in      decimal point request per digit
//   blank_lz   enable leading-zero blanking
//   Segments   {g,f,e,d,c,b,a} segment bus
//   bp         decimal point segment
//   SEL        digit enables, bit i = digit i
//   frame_tick one-cycle pulse when a new snapshot is taken
interface bcd_to_n_digit_mux_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] bcd_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  blank_lz;
  logic [6:0]            Segments;
  logic                  bp;
  logic [N_DIGITS-1:0]   SEL;
  logic                  frame_tick;

  modport master (
    output bcd_in, dp_in, blank_lz,
    input  Segments, bp, SEL, frame_tick
  );

  modport slave (
    input  bcd_in, dp_in, blank_lz,
    output Segments, bp, SEL, frame_tick
  );
endinterface

// File: rtl/bcd_to_n_digit_mux.sv
// bcd_to_n_digit_mux
//   Time-multiplexed BCD-to-7-segment driver for N_DIGITS digits sharing one
//   segment bus. Each digit owns a slot of CLK_DIV clocks; the first
//   BLANK_CYCLES of every slot keep all selects off to stop ghosting. Inputs
//   are snapshotted once per frame (start of digit 0) so a frame never mixes
//   old and new values. Optional leading-zero blanking and hex glyphs.
//   clk50MHz  system clock
//   rst_n     asynchronous active-low reset
//   bus       bcd_to_n_digit_mux_if.slave (codes in, segment/select pins out)
module bcd_to_n_digit_mux #(
  parameter int N_DIGITS       = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit HEX_MODE       = 1'b0
) (
  input  logic                  clk50MHz,
  input  logic                  rst_n,
  bcd_to_n_digit_mux_if.slave   bus
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_N = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
  // Inactive pin levels double as the XOR mask applying polarity.
  localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                BP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {N_DIGITS{1'b1}} : '0;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] g;
    case (c)
      4'd0:  g = 7'h3F;  4'd1:  g = 7'h06;  4'd2:  g = 7'h5B;  4'd3:  g = 7'h4F;
      4'd4:  g = 7'h66;  4'd5:  g = 7'h6D;  4'd6:  g = 7'h7D;  4'd7:  g = 7'h07;
      4'd8:  g = 7'h7F;  4'd9:  g = 7'h6F;
      4'd10: g = HEX_MODE ? 7'h77 : 7'h00;
      4'd11: g = HEX_MODE ? 7'h7C : 7'h00;
      4'd12: g = HEX_MODE ? 7'h39 : 7'h00;
      4'd13: g = HEX_MODE ? 7'h5E : 7'h00;
      4'd14: g = HEX_MODE ? 7'h79 : 7'h00;
      default: g = HEX_MODE ? 7'h71 : 7'h00;
    endcase
    return g;
  endfunction

  logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0] snap_bcd_q, snap_bcd_d;
  logic [N_DIGITS-1:0]      snap_dp_q, snap_dp_d;
  logic                     snap_lz_q, snap_lz_d;
  logic [6:0]               seg_q, seg_d;
  logic                     bp_q, bp_d;
  logic [N_DIGITS-1:0]      sel_q, sel_d;
  logic                     tick_q;

  logic                     take;
  logic                     run;
  logic [N_DIGITS-1:0]      lz_blank;
  logic [3:0]               cur_code;
  logic                     cur_dp, cur_dark, lit;
  logic [6:0]               seg_raw;
  logic [N_DIGITS-1:0]      sel_raw;

  // Scan counters and frame snapshot.
  always_comb begin
    take       = (div_cnt_q == '0) && (idx_q == '0);
    div_cnt_d  = div_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (div_cnt_q == DIV_MAX) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    snap_bcd_d = take ? bus.bcd_in   : snap_bcd_q;
    snap_dp_d  = take ? bus.dp_in    : snap_dp_q;
    snap_lz_d  = take ? bus.blank_lz : snap_lz_q;
  end

  // Display decode works from the snapshot in force for this cycle, so the
  // first slot of a frame already sees the freshly captured values.
  always_comb begin
    lz_blank = '0;
    run      = 1'b1;
    // run stays high while this digit and all above it are zero with no dp.
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      run         = run && (snap_bcd_d[i] == 4'd0) && !snap_dp_d[i];
      lz_blank[i] = run && snap_lz_d;
    end
    cur_code = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code = snap_bcd_d[i];
        cur_dp   = snap_dp_d[i];
        cur_dark = lz_blank[i];
      end
    end
    lit     = (div_cnt_q >= BLANK_N) && !cur_dark;
    seg_raw = lit ? glyph(cur_code) : 7'h00;
    for (int i = 0; i < N_DIGITS; i++)
      sel_raw[i] = lit && (idx_q == IDX_W'(i));
    seg_d = seg_raw ^ SEG_OFF;
    bp_d  = (lit && cur_dp) ^ BP_OFF;
    sel_d = sel_raw ^ SEL_OFF;
  end

  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      idx_q      <= '0;
      snap_bcd_q <= '0;
      snap_dp_q  <= '0;
      snap_lz_q  <= 1'b0;
      seg_q      <= SEG_OFF;
      bp_q       <= BP_OFF;
      sel_q      <= SEL_OFF;
      tick_q     <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      snap_bcd_q <= snap_bcd_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
      seg_q      <= seg_d;
      bp_q       <= bp_d;
      sel_q      <= sel_d;
      tick_q     <= take;
    end
  end

  assign bus.Segments   = seg_q;
  assign bus.bp         = bp_q;
  assign bus.SEL        = sel_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_bcd_to_n_digit_mux.sv
// tb_bcd_to_n_digit_mux
//   Drives two drivers (HEX_MODE 0 and 1) with identical directed and random
//   inputs and compares every output pin each cycle against a frame/slot
//   arithmetic model of the display.
module tb_bcd_to_n_digit_mux;
  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk50MHz = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk50MHz = ~clk50MHz;

  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        lz;

  bcd_to_n_digit_mux_if #(.N_DIGITS(N)) bus0 ();
  bcd_to_n_digit_mux_if #(.N_DIGITS(N)) bus1 ();

  assign bus0.bcd_in = bcd;  assign bus0.dp_in = dp;  assign bus0.blank_lz = lz;
  assign bus1.bcd_in = bcd;  assign bus1.dp_in = dp;  assign bus1.blank_lz = lz;

  bcd_to_n_digit_mux #(
    .N_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLK),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)
  ) u_dec (.clk50MHz(clk50MHz), .rst_n(rst_n), .bus(bus0));

  bcd_to_n_digit_mux #(
    .N_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLK),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)
  ) u_hex (.clk50MHz(clk50MHz), .rst_n(rst_n), .bus(bus1));

  int n_cmp, n_err;
  int p;                    // counter position at the next clock edge
  logic [15:0] s_bcd;
  logic [3:0]  s_dp;
  logic        s_lz;
  logic [6:0]  e_seg [2];
  logic        e_bp  [2];
  logic [3:0]  e_sel [2];
  logic        e_tick;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Expected pins for counter position pos, from slot arithmetic.
  function automatic void model(input int pos, input bit hex,
                                output logic [6:0] seg, output logic b,
                                output logic [3:0] sel);
    int   dv   = pos % DIV;
    int   ix   = (pos / DIV) % N;
    int   code = int'((s_bcd >> (4 * ix)) & 16'hF);
    bit   dark = (dv < BLK) ||
                 (s_lz && ix > 0 && (s_bcd >> (4 * ix)) == 16'h0 &&
                  (s_dp >> ix) == 4'h0);
    logic [6:0] g = (code >= 10 && !hex) ? 7'h00 : GLYPH[code];
    seg = 7'h7F;
    b   = 1'b1;
    sel = 4'hF;
    if (!dark) begin
      seg = ~g;
      b   = ~s_dp[ix];
      sel = ~(4'b0001 << ix);
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".seg0"},  32'(bus0.Segments),   32'(e_seg[0]));
    chk({tag, ".bp0"},   32'(bus0.bp),         32'(e_bp[0]));
    chk({tag, ".sel0"},  32'(bus0.SEL),        32'(e_sel[0]));
    chk({tag, ".tick0"}, 32'(bus0.frame_tick), 32'(e_tick));
    chk({tag, ".seg1"},  32'(bus1.Segments),   32'(e_seg[1]));
    chk({tag, ".bp1"},   32'(bus1.bp),         32'(e_bp[1]));
    chk({tag, ".sel1"},  32'(bus1.SEL),        32'(e_sel[1]));
    chk({tag, ".tick1"}, 32'(bus1.frame_tick), 32'(e_tick));
  endtask

  task automatic check_inactive(input string tag);
    e_seg[0] = 7'h7F; e_bp[0] = 1'b1; e_sel[0] = 4'hF;
    e_seg[1] = 7'h7F; e_bp[1] = 1'b1; e_sel[1] = 4'hF;
    e_tick   = 1'b0;
    check_all(tag);
  endtask

  // One clock: update model for the coming edge, then compare at negedge.
  task automatic cycle(input string tag);
    if (p % FRAME == 0) begin
      s_bcd = bcd; s_dp = dp; s_lz = lz;
    end
    e_tick = (p % FRAME == 0);
    model(p, 1'b0, e_seg[0], e_bp[0], e_sel[0]);
    model(p, 1'b1, e_seg[1], e_bp[1], e_sel[1]);
    p++;
    @(negedge clk50MHz);
    check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Called at a negedge: pulse reset for 3 ns well clear of the rising edge.
  task automatic mid_reset();
    #1 rst_n = 1'b0;
    #1 check_inactive("async_rst");
    #2 rst_n = 1'b1;
    p = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; p = 0;
    s_bcd = '0; s_dp = '0; s_lz = 1'b0;
    bcd = 16'h1234; dp = 4'b0100; lz = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk50MHz);
    check_inactive("reset");
    rst_n = 1'b1;
    run(2 * FRAME, "scan1234");

    bcd = 16'h0070; dp = 4'b0000; lz = 1'b1;
    run(2 * FRAME, "lz0070");
    bcd = 16'h0000;
    run(2 * FRAME, "lz0000");
    bcd = 16'h0005; dp = 4'b0010;
    run(2 * FRAME, "lzdp");

    // Change inputs mid-frame (digit 2 slot); frame must stay coherent.
    bcd = 16'h1234; dp = 4'b0000; lz = 1'b0;
    run(FRAME, "tear_pre");
    run(2 * DIV + 3, "tear_a");
    bcd = 16'h9999;
    run(FRAME - (2 * DIV + 3) + FRAME, "tear_b");

    // Asynchronous reset during the lit part of the digit 2 slot.
    run(2 * DIV + 4, "pre_rst");
    mid_reset();
    run(FRAME, "post_rst");

    bcd = 16'h000A; dp = 4'b0000; lz = 1'b0;
    run(FRAME, "hex");

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        bcd = 16'($urandom);
        if ($urandom_range(0, 1) == 0) bcd = bcd & 16'h00FF;
        dp  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        lz  = 1'($urandom);
      end
      if ($urandom_range(0, 299) == 0) mid_reset();
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
